// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use hazard control for a five-stage pipeline.
// Picks each EX operand from EX/MEM, MEM/WB, a one-cycle write-back hold
// register or the register file, and stretches load-use stalls to LOAD_LAT
// bubbles while keeping a saturating count of stall cycles.
module fwd_hazard_unit #(
   parameter int DATA_W    = 32,
   parameter int AW        = 5,
   parameter int LOAD_LAT  = 1,
   parameter int WB_BYPASS = 1,
   parameter int CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [AW-1:0]     ifid_rs,
   input  logic [AW-1:0]     ifid_rt,
   input  logic [AW-1:0]     idex_rs,
   input  logic [AW-1:0]     idex_rt,
   input  logic [AW-1:0]     idex_rd,
   input  logic              idex_memread,
   input  logic              idex_regwrite,
   input  logic [DATA_W-1:0] idex_rs_data,
   input  logic [DATA_W-1:0] idex_rt_data,
   input  logic [AW-1:0]     exmem_rd,
   input  logic [AW-1:0]     memwb_rd,
   input  logic              exmem_regwrite,
   input  logic              memwb_regwrite,
   input  logic [DATA_W-1:0] exmem_data,
   input  logic [DATA_W-1:0] memwb_data,
   input  logic              cnt_clr,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic [DATA_W-1:0] op_a,
   output logic [DATA_W-1:0] op_b,
   output logic              stall,
   output logic              bubble,
   output logic [CNT_W-1:0]  stall_cnt
);

   typedef enum logic {RUN, STALL} state_t;

   state_t             state_q, state_d;
   logic [2:0]         bcnt_q, bcnt_d;
   logic [AW-1:0]      hold_rd_q;
   logic [DATA_W-1:0]  hold_data_q;
   logic               hold_we_q;
   logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
   logic               detect;
   logic               stall_raw;

   // Source selection for one operand; register 0 is never forwarded.
   function automatic logic [1:0] fwd_sel(input logic [AW-1:0] r);
      logic [1:0] s;
      s = 2'b00;
      if (r != '0) begin
         if (exmem_regwrite && exmem_rd == r)
            s = 2'b10;
         else if (memwb_regwrite && memwb_rd == r)
            s = 2'b01;
         else if ((WB_BYPASS != 0) && hold_we_q && hold_rd_q == r)
            s = 2'b11;
      end
      return s;
   endfunction

   function automatic logic [DATA_W-1:0] fwd_mux(input logic [1:0] s,
                                                 input logic [DATA_W-1:0] rf);
      logic [DATA_W-1:0] v;
      case (s)
         2'b10:   v = exmem_data;
         2'b01:   v = memwb_data;
         2'b11:   v = hold_data_q;
         default: v = rf;
      endcase
      return v;
   endfunction

   // Combinational forwarding for both operands, active in every state.
   always_comb begin
      fwd_a = fwd_sel(idex_rs);
      fwd_b = fwd_sel(idex_rt);
      op_a  = fwd_mux(fwd_a, idex_rs_data);
      op_b  = fwd_mux(fwd_b, idex_rt_data);
   end

   assign detect = idex_memread && idex_regwrite && (idex_rd != '0) &&
                   ((idex_rd == ifid_rs) || (idex_rd == ifid_rt));

   // Keep the retiring write-back result one more cycle as a third source.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_rd_q   <= '0;
         hold_data_q <= '0;
         hold_we_q   <= 1'b0;
      end else begin
         hold_rd_q   <= memwb_rd;
         hold_data_q <= memwb_data;
         hold_we_q   <= memwb_regwrite;
      end
   end

   // Stall FSM state and remaining-bubble counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         bcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         bcnt_q  <= bcnt_d;
      end
   end

   // Next state: the detecting cycle is the first bubble, STALL adds the rest.
   always_comb begin
      state_d   = state_q;
      bcnt_d    = bcnt_q;
      stall_raw = 1'b0;
      case (state_q)
         RUN: begin
            stall_raw = detect;
            if (detect && (LOAD_LAT > 1)) begin
               state_d = STALL;
               bcnt_d  = 3'(LOAD_LAT - 1);
            end
         end
         STALL: begin
            stall_raw = 1'b1;
            bcnt_d    = bcnt_q - 3'd1;
            if (bcnt_q <= 3'd1) begin
               state_d = RUN;
               bcnt_d  = '0;
            end
         end
         default: begin
            state_d = RUN;
            bcnt_d  = '0;
         end
      endcase
   end

   // Hazard outputs are forced low while reset is asserted.
   always_comb begin
      stall  = stall_raw & rst_n;
      bubble = stall_raw & rst_n;
   end

   // Saturating stall-cycle counter; clear takes precedence.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (cnt_clr)
         stall_cnt_d = '0;
      else if (stall_raw && !(&stall_cnt_q))
         stall_cnt_d = stall_cnt_q + 1'b1;
   end

   // Stall counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_cnt_q <= '0;
      else
         stall_cnt_q <= stall_cnt_d;
   end

   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit. Two instances share one stimulus:
// u1 (LOAD_LAT=3, WB_BYPASS=1, CNT_W=4) and u2 (LOAD_LAT=1, WB_BYPASS=0, CNT_W=16).
module tb_fwd_hazard_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  ifid_rs, ifid_rt, idex_rs, idex_rt, idex_rd;
   logic        idex_memread, idex_regwrite;
   logic [31:0] idex_rs_data, idex_rt_data;
   logic [4:0]  exmem_rd, memwb_rd;
   logic        exmem_regwrite, memwb_regwrite;
   logic [31:0] exmem_data, memwb_data;
   logic        cnt_clr;

   logic [1:0]  fwd_a_1, fwd_b_1, fwd_a_2, fwd_b_2;
   logic [31:0] op_a_1, op_b_1, op_a_2, op_b_2;
   logic        stall_1, bubble_1, stall_2, bubble_2;
   logic [3:0]  cnt_1;
   logic [15:0] cnt_2;

   int n_tot = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   fwd_hazard_unit #(.DATA_W(32), .AW(5), .LOAD_LAT(3), .WB_BYPASS(1), .CNT_W(4)) u1 (
      .clk(clk), .rst_n(rst_n),
      .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
      .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_rd(idex_rd),
      .idex_memread(idex_memread), .idex_regwrite(idex_regwrite),
      .idex_rs_data(idex_rs_data), .idex_rt_data(idex_rt_data),
      .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
      .exmem_regwrite(exmem_regwrite), .memwb_regwrite(memwb_regwrite),
      .exmem_data(exmem_data), .memwb_data(memwb_data),
      .cnt_clr(cnt_clr),
      .fwd_a(fwd_a_1), .fwd_b(fwd_b_1), .op_a(op_a_1), .op_b(op_b_1),
      .stall(stall_1), .bubble(bubble_1), .stall_cnt(cnt_1)
   );

   fwd_hazard_unit #(.DATA_W(32), .AW(5), .LOAD_LAT(1), .WB_BYPASS(0), .CNT_W(16)) u2 (
      .clk(clk), .rst_n(rst_n),
      .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
      .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_rd(idex_rd),
      .idex_memread(idex_memread), .idex_regwrite(idex_regwrite),
      .idex_rs_data(idex_rs_data), .idex_rt_data(idex_rt_data),
      .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
      .exmem_regwrite(exmem_regwrite), .memwb_regwrite(memwb_regwrite),
      .exmem_data(exmem_data), .memwb_data(memwb_data),
      .cnt_clr(cnt_clr),
      .fwd_a(fwd_a_2), .fwd_b(fwd_b_2), .op_a(op_a_2), .op_b(op_b_2),
      .stall(stall_2), .bubble(bubble_2), .stall_cnt(cnt_2)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      ifid_rs = '0; ifid_rt = '0; idex_rs = '0; idex_rt = '0; idex_rd = '0;
      idex_memread = 1'b0; idex_regwrite = 1'b0;
      idex_rs_data = '0; idex_rt_data = '0;
      exmem_rd = '0; memwb_rd = '0; exmem_regwrite = 1'b0; memwb_regwrite = 1'b0;
      exmem_data = '0; memwb_data = '0; cnt_clr = 1'b0;
   endtask

   initial begin
      clear_inputs();
      rst_n = 1'b0;

      // Reset: hazard outputs low even with a load-use pattern present.
      idex_memread = 1'b1; idex_regwrite = 1'b1; idex_rd = 5'd7; ifid_rs = 5'd7;
      idex_rs = 5'd3; exmem_rd = 5'd3; exmem_regwrite = 1'b1; exmem_data = 32'h1234;
      #2;
      chk("rst_stall1", stall_1, 1'b0);
      chk("rst_bubble1", bubble_1, 1'b0);
      chk("rst_stall2", stall_2, 1'b0);
      chk("rst_cnt1", cnt_1, 4'd0);
      chk("rst_fwd_a", fwd_a_1, 2'b10);
      chk("rst_op_a", op_a_1, 32'h1234);
      step();
      step();
      clear_inputs();
      rst_n = 1'b1;
      #1;
      chk("post_rst_stall", stall_1, 1'b0);

      // EX/MEM beats MEM/WB on the same register.
      exmem_rd = 5'd3; memwb_rd = 5'd3; exmem_regwrite = 1'b1; memwb_regwrite = 1'b1;
      idex_rs = 5'd3; exmem_data = 32'hA; memwb_data = 32'hB; idex_rs_data = 32'hC;
      #1;
      chk("prio_fwd_a", fwd_a_1, 2'b10);
      chk("prio_op_a", op_a_1, 32'hA);
      exmem_regwrite = 1'b0;
      #1;
      chk("memwb_fwd_a", fwd_a_1, 2'b01);
      chk("memwb_op_a", op_a_1, 32'hB);

      // Register 0 is never forwarded.
      exmem_rd = 5'd0; exmem_regwrite = 1'b1; exmem_data = 32'hDEAD;
      idex_rt = 5'd0; idex_rt_data = 32'h0;
      #1;
      chk("r0_fwd_b", fwd_b_1, 2'b00);
      chk("r0_op_b", op_b_1, 32'h0);
      idex_rt_data = 32'h77;
      #1;
      chk("r0_op_b_rf", op_b_1, 32'h77);
      step();

      // WB-hold: capture 5/0x55, then MEM/WB no longer writes.
      clear_inputs();
      memwb_rd = 5'd5; memwb_regwrite = 1'b1; memwb_data = 32'h55;
      step();
      memwb_regwrite = 1'b0; memwb_data = 32'h99;
      idex_rs = 5'd5; idex_rs_data = 32'h11;
      #1;
      chk("hold_fwd_a1", fwd_a_1, 2'b11);
      chk("hold_op_a1", op_a_1, 32'h55);
      chk("hold_fwd_a2", fwd_a_2, 2'b00);
      chk("hold_op_a2", op_a_2, 32'h11);
      step();
      #1;
      chk("hold_stale", fwd_a_1, 2'b00);
      // MEM/WB outranks a matching hold entry.
      memwb_regwrite = 1'b1; memwb_data = 32'h66;
      step();
      chk("memwb_over_hold", fwd_a_1, 2'b01);
      chk("memwb_over_hold_op", op_a_1, 32'h66);
      memwb_regwrite = 1'b0;
      #1;
      chk("hold_66", op_a_1, 32'h66);
      step();

      // Load-use with LOAD_LAT=3 on u1 and LOAD_LAT=1 on u2.
      clear_inputs();
      #1;
      chk("cnt_before", cnt_1, 4'd0);
      idex_memread = 1'b1; idex_regwrite = 1'b1; idex_rd = 5'd7; ifid_rs = 5'd7;
      #1;
      chk("lu_c1_stall1", stall_1, 1'b1);
      chk("lu_c1_bubble1", bubble_1, 1'b1);
      chk("lu_c1_stall2", stall_2, 1'b1);
      step();
      idex_memread = 1'b0; idex_regwrite = 1'b0; idex_rd = 5'd0;
      #1;
      chk("lu_c2_stall1", stall_1, 1'b1);
      chk("lu_c2_stall2", stall_2, 1'b0);
      step();
      chk("lu_c3_stall1", bubble_1, 1'b1);
      step();
      chk("lu_c4_stall1", stall_1, 1'b0);
      chk("lu_cnt1", cnt_1, 4'd3);
      chk("lu_cnt2", cnt_2, 16'd1);

      // Load to r0 and a load matching on rt.
      idex_memread = 1'b1; idex_regwrite = 1'b1; idex_rd = 5'd0; ifid_rs = 5'd0;
      #1;
      chk("lu_r0", stall_1, 1'b0);
      idex_rd = 5'd9; ifid_rs = 5'd2; ifid_rt = 5'd9;
      #1;
      chk("lu_rt", stall_2, 1'b1);
      idex_regwrite = 1'b0;
      #1;
      chk("lu_noregwrite", stall_1, 1'b0);

      // Reset during the second bubble aborts the stall.
      idex_regwrite = 1'b1;
      step();
      clear_inputs();
      #1;
      chk("abort_c2", stall_1, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("abort_stall", stall_1, 1'b0);
      chk("abort_cnt", cnt_1, 4'd0);
      step();
      rst_n = 1'b1;
      #1;
      chk("abort_rel", stall_1, 1'b0);
      step();
      chk("abort_after", stall_1, 1'b0);
      chk("abort_cnt_after", cnt_1, 4'd0);

      // Continuous stall: 4-bit counter saturates, 16-bit one counts on.
      idex_memread = 1'b1; idex_regwrite = 1'b1; idex_rd = 5'd4; ifid_rs = 5'd4;
      for (int i = 0; i < 20; i++) step();
      chk("sat_stall", stall_1, 1'b1);
      chk("sat_cnt1", cnt_1, 4'd15);
      chk("sat_cnt2", cnt_2, 16'd20);
      cnt_clr = 1'b1;
      step();
      chk("clr_cnt1", cnt_1, 4'd0);
      chk("clr_cnt2", cnt_2, 16'd0);
      clear_inputs();
      #1;
      chk("clr_idle_stall", stall_1, 1'b0);
      step();
      chk("clr_idle_cnt", cnt_1, 4'd0);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 Parameters SHALL be (one per line: name, default, meaning):
  DATA_W, 32, operand/result data width
  AW, 5, register address width
  LOAD_LAT, 1, load-use bubble cycles (legal 1..4)
  WB_BYPASS, 1, 1 enables write-back hold register (third forwarding source)
  CNT_W, 16, stall counter width
REQ-002 Ports SHALL be (name direction width meaning):
  clk  in  1  single clock, rising edge
  rst_n  in  1  reset, asynchronous, active-low
  ifid_rs, ifid_rt  in  AW  source regs of instruction in ID
  idex_rs, idex_rt  in  AW  source regs of instruction in EX
  idex_rd  in  AW  dest reg of instruction in EX
  idex_memread, idex_regwrite  in  1  EX instruction is load / writes reg
  idex_rs_data, idex_rt_data  in  DATA_W  register-file read values
  exmem_rd, memwb_rd  in  AW  dest regs in MEM, WB
  exmem_regwrite, memwb_regwrite  in  1  write enables in MEM, WB
  exmem_data, memwb_data  in  DATA_W  result values in MEM, WB
  cnt_clr  in  1  synchronous clear of stall_cnt
  fwd_a, fwd_b  out  2  selected source per operand
  op_a, op_b  out  DATA_W  forwarded operands
  stall  out  1  hold PC and IF/ID
  bubble  out  1  insert NOP into ID/EX
  stall_cnt  out  CNT_W  saturating stall-cycle count
REQ-003 Clock is clk; reset is rst_n, asynchronous, active-low; single clock domain.

Function
REQ-004 fwd encoding SHALL be 00 regfile, 10 EX/MEM, 01 MEM/WB, 11 WB-hold; op_x SHALL be the data of the selected source, combinational.
REQ-005 Source match for operand rs (same rule for rt): source regwrite=1, source rd==idex_rs, source rd!=0.
REQ-006 Priority SHALL be EX/MEM > MEM/WB > WB-hold > regfile; register 0 SHALL always select regfile.
REQ-007 WB-hold register SHALL capture memwb_rd, memwb_data, memwb_regwrite every clock; its match SHALL use the captured values; WB_BYPASS=0 SHALL never produce fwd=11.
REQ-008 Load-use detect = idex_memread & idex_regwrite & idex_rd!=0 & (idex_rd==ifid_rs | idex_rd==ifid_rt).
REQ-009 FSM states RUN, STALL; in RUN, stall=bubble=detect.
REQ-010 RUN with detect and LOAD_LAT>1 SHALL go to STALL with bcnt=LOAD_LAT-1; LOAD_LAT=1 SHALL remain in RUN.
REQ-011 In STALL, stall=bubble=1 regardless of detect; bcnt decrements each cycle; bcnt==1 SHALL return to RUN next edge.
REQ-012 Total bubbles per load-use event SHALL equal LOAD_LAT exactly.
REQ-013 stall_cnt SHALL increment on each edge with stall=1, saturate at 2^CNT_W-1, and cnt_clr SHALL win over increment.
REQ-014 Forwarding SHALL operate normally in all FSM states (EX instruction is a bubble during stall and carries regwrite=0).

Reset
REQ-015 While rst_n=0: state=RUN, bcnt=0, WB-hold regwrite=0/rd=0/data=0, stall_cnt=0, stall=0, bubble=0.
REQ-016 Reset asserted mid-STALL SHALL abort immediately to RUN; no residual bubbles after release.
REQ-017 fwd_a/fwd_b/op_a/op_b remain combinational under reset, with the WB-hold source invalid.

Verification
REQ-018 exmem_rd=memwb_rd=3, both regwrite=1, idex_rs=3, exmem_data=0xA, memwb_data=0xB -> fwd_a=10, op_a=0xA.
REQ-019 exmem_rd=0, exmem_regwrite=1, idex_rt=0, idex_rt_data=0 -> fwd_b=00, op_b=0.
REQ-020 memwb_rd=5, regwrite=1, data=0x55 one cycle, then memwb_regwrite=0; idex_rs=5 next cycle -> fwd_a=11, op_a=0x55 (WB_BYPASS=1); fwd_a=00 with WB_BYPASS=0.
REQ-021 LOAD_LAT=3, idex load to rd=7, ifid_rs=7 -> stall=bubble=1 for exactly 3 cycles, stall_cnt +3.
REQ-022 LOAD_LAT=3, rst_n low during 2nd bubble -> stall=0 immediately, state RUN, stall_cnt=0 after release.
REQ-023 CNT_W=4, stall held 20 cycles -> stall_cnt=15; cnt_clr with stall=1 -> stall_cnt=0 next edge.
